// File: rtl/stopwatch_counter.sv
// Stopwatch time base: divides the input clock to a count tick and accumulates
// h:m:s.cs while running, with lap freeze and clear-while-stopped.
module stopwatch_counter #(
   parameter int CLOCK_HZ = 50_000_000,
   parameter int TICK_HZ  = 100,
   parameter int HOUR_MOD = 24
) (
   input  logic       clock_50m,
   input  logic       reset,
   input  logic       run,
   input  logic       lap,
   input  logic       clear,
   output logic [5:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [6:0] m_sec,
   output logic       lap_active,
   output logic       tick
);

   localparam int DIV   = CLOCK_HZ / TICK_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
   localparam logic [5:0]       HOUR_LAST = 6'(HOUR_MOD - 1);

   typedef struct packed {
      logic [5:0] hh;
      logic [5:0] mm;
      logic [5:0] ss;
      logic [6:0] cs;
   } time_t;

   typedef enum logic {LIVE, FROZEN} lap_state_t;

   lap_state_t       state_reg, state_next;
   logic [PRE_W-1:0] pre_reg, pre_next;
   time_t            live_reg, live_next;
   time_t            snap_reg, snap_next;
   time_t            disp_reg, disp_next;
   time_t            live_inc;
   logic             tick_reg, tick_next;
   logic             step;
   logic             clear_eff;

   // Full carry chain resolved in one cycle.
   always_comb begin
      live_inc = live_reg;
      if (live_reg.cs == 7'd99) begin
         live_inc.cs = '0;
         if (live_reg.ss == 6'd59) begin
            live_inc.ss = '0;
            if (live_reg.mm == 6'd59) begin
               live_inc.mm = '0;
               live_inc.hh = (live_reg.hh == HOUR_LAST) ? 6'd0 : live_reg.hh + 6'd1;
            end else begin
               live_inc.mm = live_reg.mm + 6'd1;
            end
         end else begin
            live_inc.ss = live_reg.ss + 6'd1;
         end
      end else begin
         live_inc.cs = live_reg.cs + 7'd1;
      end
   end

   always_comb begin
      state_next = state_reg;
      pre_next   = pre_reg;
      live_next  = live_reg;
      snap_next  = snap_reg;
      tick_next  = 1'b0;
      step       = run && (pre_reg == PRE_LAST);
      clear_eff  = clear && !run;

      if (clear_eff) begin
         pre_next   = '0;
         live_next  = '0;
         state_next = LIVE;
      end else begin
         if (run) begin
            pre_next = step ? '0 : pre_reg + 1'b1;
         end
         if (step) begin
            live_next = live_inc;
            tick_next = 1'b1;
         end
         // Snapshot takes the pre-increment value of the freeze cycle.
         if (lap) begin
            case (state_reg)
               LIVE: begin
                  if (run) begin
                     state_next = FROZEN;
                     snap_next  = live_reg;
                  end
               end
               FROZEN:  state_next = LIVE;
               default: state_next = LIVE;
            endcase
         end
      end

      // Display is registered from next-state values so it tracks the live count with no extra lag.
      disp_next = (state_next == FROZEN) ? snap_next : live_next;
   end

   always_ff @(posedge clock_50m) begin
      if (reset) begin
         state_reg <= LIVE;
         pre_reg   <= '0;
         live_reg  <= '0;
         snap_reg  <= '0;
         disp_reg  <= '0;
         tick_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         pre_reg   <= pre_next;
         live_reg  <= live_next;
         snap_reg  <= snap_next;
         disp_reg  <= disp_next;
         tick_reg  <= tick_next;
      end
   end

   assign hour       = disp_reg.hh;
   assign minute     = disp_reg.mm;
   assign second     = disp_reg.ss;
   assign m_sec      = disp_reg.cs;
   assign lap_active = (state_reg == FROZEN);
   assign tick       = tick_reg;

endmodule
